// File: rtl/hart_arb_pkg.sv
// Shared definitions for the cluster hart arbiters: FSM encoding, mode
// constants and the round-robin next-requester search.
package hart_arb_pkg;

    localparam int MAX_HARTS = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_SWITCH = 2'd2
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Returns {found, index}: first requester after 'last', wrapping modulo n.
    function automatic logic [4:0] rr_search(input logic [MAX_HARTS-1:0] req,
                                             input logic [3:0] last,
                                             input int unsigned n);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int unsigned k = 1; k <= MAX_HARTS; k++) begin
            idx = 4'((32'(last) + k) % n);
            if (k <= n && !res[4] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: request vector plus last-winner pointer
// to one-hot winner and binary index.
module rr_pick
    import hart_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [4:0] res_s;

    // Scan from last+1 with wrap; a pointer of N-1 yields plain lowest-index priority.
    always_comb begin
        res_s  = rr_search(MAX_HARTS'(req), 4'(last), N);
        valid  = res_s[4];
        idx    = IW'(res_s[3:0]);
        if (res_s[4]) begin
            onehot = N'(1) << idx;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shared memory port arbiter for N_HARTS harts with quantum-limited grants.
// Optional macro ARB_LOCK_EN adds w_lock to pin the grant during atomic sequences.
module hart_mem_arbiter
    import hart_arb_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter int QUANTUM = 4,
    localparam int SEL_W  = (N_HARTS > 1) ? $clog2(N_HARTS) : 1,
    localparam int CNT_W  = $clog2(QUANTUM + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_HARTS-1:0]         w_req,
    input  logic [N_HARTS*ADDR_W-1:0]  w_addr,
    input  logic [N_HARTS*DATA_W-1:0]  w_wdata,
    input  logic [N_HARTS*CTRL_W-1:0]  w_ctrl,
    input  logic [N_HARTS-1:0]         w_we,
`ifdef ARB_LOCK_EN
    input  logic [N_HARTS-1:0]         w_lock,
`endif
    input  logic                       w_mode_rr,
    input  logic                       w_hold,
    input  logic                       w_mem_busy,
    input  logic                       w_mem_done,
    output logic [N_HARTS-1:0]         r_grant,
    output logic [SEL_W-1:0]           r_sel,
    output logic                       w_sel_valid,
    output logic [ADDR_W-1:0]          w_out_addr,
    output logic [DATA_W-1:0]          w_out_wdata,
    output logic [CTRL_W-1:0]          w_out_ctrl,
    output logic                       w_out_we,
    output logic [N_HARTS-1:0]         w_hart_busy
);

    localparam logic [CNT_W-1:0] Q_MAX = CNT_W'(QUANTUM);

    arb_state_e          state_r, state_nx_s;
    logic [SEL_W-1:0]    last_r, last_nx_s, sel_nx_s, ptr_s, pick_idx_s;
    logic [N_HARTS-1:0]  grant_nx_s, pick_onehot_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s, cnt_inc_s;
    logic                pick_valid_s, own_req_s, others_s, locked_s, stay_s;

`ifdef ARB_LOCK_EN
    assign locked_s = w_lock[r_sel];
`else
    assign locked_s = 1'b0;
`endif

    assign ptr_s     = (w_mode_rr == MODE_RR) ? last_r : SEL_W'(N_HARTS - 1);
    assign own_req_s = w_req[r_sel];
    assign others_s  = |(w_req & ~r_grant);
    assign cnt_inc_s = (cnt_r >= Q_MAX) ? Q_MAX : cnt_r + CNT_W'(1);

    rr_pick #(.N(N_HARTS), .IW(SEL_W)) u_pick (
        .req    (w_req),
        .last   (ptr_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // State and grant registers; reset drops any grant without waiting for done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            last_r  <= SEL_W'(N_HARTS - 1);
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            r_grant <= grant_nx_s;
            r_sel   <= sel_nx_s;
            last_r  <= last_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state: arbitration in idle/bubble, continuation rules on each done.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = r_grant;
        sel_nx_s   = r_sel;
        last_nx_s  = last_r;
        cnt_nx_s   = cnt_r;
        stay_s     = 1'b1;
        case (state_r)
            S_IDLE, S_SWITCH: begin
                grant_nx_s = '0;
                if (!w_hold && pick_valid_s) begin
                    state_nx_s = S_ACTIVE;
                    grant_nx_s = pick_onehot_s;
                    sel_nx_s   = pick_idx_s;
                    last_nx_s  = pick_idx_s;
                    cnt_nx_s   = '0;
                end else if (state_r == S_SWITCH && w_hold) begin
                    state_nx_s = S_SWITCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (w_mem_done) begin
                    cnt_nx_s = cnt_inc_s;
                    if (locked_s) begin
                        stay_s = 1'b1;
                    end else if (!own_req_s) begin
                        stay_s = 1'b0;
                    end else if (w_mode_rr == MODE_FIXED) begin
                        stay_s = 1'b1;
                    end else if (cnt_inc_s < Q_MAX) begin
                        stay_s = 1'b1;
                    end else if (!others_s) begin
                        // Quantum expired but nobody else wants the port: restart, no bubble.
                        stay_s   = 1'b1;
                        cnt_nx_s = '0;
                    end else begin
                        stay_s = 1'b0;
                    end
                    if (!stay_s && !w_hold) begin
                        state_nx_s = S_SWITCH;
                        grant_nx_s = '0;
                        cnt_nx_s   = '0;
                    end else begin
                        state_nx_s = S_ACTIVE;
                    end
                end else begin
                    state_nx_s = S_ACTIVE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                grant_nx_s = '0;
            end
        endcase
    end

    // Output mux from the registered selection, zeroed when nothing is granted.
    always_comb begin
        w_sel_valid = |r_grant;
        w_hart_busy = ~r_grant | (r_grant & {N_HARTS{w_mem_busy}});
        if (w_sel_valid) begin
            w_out_addr  = w_addr[int'(r_sel)*ADDR_W +: ADDR_W];
            w_out_wdata = w_wdata[int'(r_sel)*DATA_W +: DATA_W];
            w_out_ctrl  = w_ctrl[int'(r_sel)*CTRL_W +: CTRL_W];
            w_out_we    = w_we[r_sel];
        end else begin
            w_out_addr  = '0;
            w_out_wdata = '0;
            w_out_ctrl  = '0;
            w_out_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Vector-table bench for hart_mem_arbiter (N_HARTS=2, QUANTUM=4) with an
// expected-output queue; the lock sequence is exercised when ARB_LOCK_EN is set.
module tb_hart_mem_arbiter;

    localparam logic [31:0] A0 = 32'h1000_00A0;
    localparam logic [31:0] A1 = 32'h2000_00B1;
    localparam logic [31:0] D0 = 32'hDEAD_0000;
    localparam logic [31:0] D1 = 32'hBEEF_0001;
    localparam logic [2:0]  C0 = 3'd5;
    localparam logic [2:0]  C1 = 3'd2;

    typedef logic [73:0] obs_t;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       rr;
        logic       hold;
        logic       busy;
        logic       done;
        logic [1:0] lock;
        logic [1:0] g;
        logic       sel;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  w_req;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [5:0]  w_ctrl;
    logic [1:0]  w_we;
    logic [1:0]  w_lock;
    logic        w_mode_rr, w_hold, w_mem_busy, w_mem_done;
    logic [1:0]  r_grant;
    logic        r_sel;
    logic        w_sel_valid;
    logic [31:0] w_out_addr;
    logic [31:0] w_out_wdata;
    logic [2:0]  w_out_ctrl;
    logic        w_out_we;
    logic [1:0]  w_hart_busy;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    hart_mem_arbiter #(.N_HARTS(2), .ADDR_W(32), .DATA_W(32), .CTRL_W(3), .QUANTUM(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .w_req       (w_req),
        .w_addr      (w_addr),
        .w_wdata     (w_wdata),
        .w_ctrl      (w_ctrl),
        .w_we        (w_we),
`ifdef ARB_LOCK_EN
        .w_lock      (w_lock),
`endif
        .w_mode_rr   (w_mode_rr),
        .w_hold      (w_hold),
        .w_mem_busy  (w_mem_busy),
        .w_mem_done  (w_mem_done),
        .r_grant     (r_grant),
        .r_sel       (r_sel),
        .w_sel_valid (w_sel_valid),
        .w_out_addr  (w_out_addr),
        .w_out_wdata (w_out_wdata),
        .w_out_ctrl  (w_out_ctrl),
        .w_out_we    (w_out_we),
        .w_hart_busy (w_hart_busy)
    );

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic rr,
                                input logic hold, input logic busy, input logic done,
                                input logic [1:0] lock, input logic [1:0] g, input logic sel);
        vec_t v;
        v.rst = rst; v.req = req; v.rr = rr; v.hold = hold; v.busy = busy;
        v.done = done; v.lock = lock; v.g = g; v.sel = sel;
        return v;
    endfunction

    // Expected outputs from the expected grant: hart 0 writes, hart 1 reads.
    function automatic obs_t model(input logic [1:0] g, input logic sel, input logic busy);
        logic [31:0] a, d;
        logic [2:0]  c;
        logic        we;
        a = 32'd0; d = 32'd0; c = 3'd0; we = 1'b0;
        if (g == 2'b01) begin
            a = A0; d = D0; c = C0; we = 1'b1;
        end else if (g == 2'b10) begin
            a = A1; d = D1; c = C1; we = 1'b0;
        end
        return {g, sel, |g, a, d, c, we, ~g | (g & {2{busy}})};
    endfunction

    function automatic obs_t observe();
        return {r_grant, r_sel, w_sel_valid, w_out_addr, w_out_wdata, w_out_ctrl, w_out_we, w_hart_busy};
    endfunction

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        RST = v.rst; w_req = v.req; w_mode_rr = v.rr; w_hold = v.hold;
        w_mem_busy = v.busy; w_mem_done = v.done; w_lock = v.lock;
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            apply(vecs[i]);
            exp_q.push_back(model(vecs[i].g, vecs[i].sel, vecs[i].busy));
            @(posedge CLK);
            #1;
            check($sformatf("%s_vec%0d", tag, i), observe(), exp_q.pop_front());
        end
        vecs.delete();
    endtask

    initial begin
        int cyc;
        RST = 1'b1; w_req = 2'b00; w_mode_rr = 1'b1; w_hold = 1'b0;
        w_mem_busy = 1'b0; w_mem_done = 1'b0; w_lock = 2'b00;
        w_addr = {A1, A0}; w_wdata = {D1, D0}; w_ctrl = {C1, C0}; w_we = 2'b01;

        // Reset, RR rotation after four dones with one-cycle bubble.
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        // Lone requester keeps the port across quantum expiry.
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1));
        // Request drop without done holds the grant; done then releases it.
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        // Hold in idle blocks the grant.
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        // Fixed priority ignores the quantum.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        // Hold in active suppresses rotation; counter saturates.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        // Hold stretches the switch bubble.
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        // Reset mid-transaction with memory busy.
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        run_vectors("main");

        // Count dones until the quantum forces a release, bounded to 10 cycles.
        cyc = 0;
        do begin
            @(negedge CLK);
            w_req = 2'b11; w_mem_done = 1'b1; w_mode_rr = 1'b1;
            @(posedge CLK);
            #1;
            cyc++;
        end while (r_grant != 2'b00 && cyc < 10);
        check("quantum_len", 74'(cyc), 74'(4));
        @(negedge CLK);
        w_mem_done = 1'b0;
        @(posedge CLK);
        #1;
        check("after_bubble", observe(), model(2'b10, 1'b1, 1'b0));

`ifdef ARB_LOCK_EN
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
        run_vectors("lock");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
